// File: rtl/trx_ctrl_shifter.sv
// trx_ctrl_shifter: serialises register-bank control words onto a
// 74HC595-style chain (ser_clk/ser_data/ser_latch), MSB first.
// Ports: ACLK, ARESETN (async low); in_data/in_valid word strobe;
//        ser_clk, ser_data, ser_latch to the RF board;
//        busy, done (1-cycle pulse), overrun (sticky until reset).
module trx_ctrl_shifter #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  ser_clk,
    output logic                  ser_data,
    output logic                  ser_latch,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0]    LAT_LAST = 4'(LATCH_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    state_t                state, state_n;
    logic [7:0]            div_cnt, div_n;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic [3:0]            lat_cnt, lat_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [DATA_WIDTH-1:0] pend_reg, pend_reg_n;
    logic                  pend_full, pend_full_n;
    logic                  consume;
    logic                  ovr_n;
    logic                  ser_clk_n, ser_data_n, ser_latch_n;
    logic                  busy_n, done_n;

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        lat_n   = lat_cnt;
        shreg_n = shreg;
        consume = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_full) begin
                    consume = 1'b1;
                    shreg_n = pend_reg;
                    div_n   = '0;
                    bit_n   = '0;
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_cnt == DIV_LAST) begin
                    div_n   = '0;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (bit_cnt < BIT_LAST) begin
                        // next bit appears on the falling edge,
                        // a full half-period before the next rise
                        shreg_n = {shreg[DATA_WIDTH-2:0], 1'b0};
                        bit_n   = bit_cnt + 1'b1;
                        state_n = SHIFT_LO;
                    end else begin
                        lat_n   = '0;
                        state_n = LATCH;
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            LATCH: begin
                if (lat_cnt == LAT_LAST) begin
                    lat_n   = '0;
                    state_n = DONE;
                end else begin
                    lat_n = lat_cnt + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // A word arriving on the consume edge refills the buffer while the
    // old word moves into the shifter; only an unconsumed overwrite
    // counts as an overrun.
    always_comb begin
        pend_full_n = in_valid | (pend_full & ~consume);
        pend_reg_n  = in_valid ? in_data : pend_reg;
        ovr_n       = overrun | (in_valid & pend_full & ~consume);
    end

    // Outputs are decoded from next-state values and registered.
    always_comb begin
        ser_clk_n   = (state_n == SHIFT_HI);
        ser_latch_n = (state_n == LATCH);
        done_n      = (state_n == DONE);
        busy_n      = (state_n != IDLE) | pend_full_n;
        ser_data_n  = 1'b0;
        if (state_n == SHIFT_LO || state_n == SHIFT_HI ||
            state_n == LATCH) begin
            ser_data_n = shreg_n[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            lat_cnt   <= '0;
            shreg     <= '0;
            pend_reg  <= '0;
            pend_full <= 1'b0;
            overrun   <= 1'b0;
            ser_clk   <= 1'b0;
            ser_data  <= 1'b0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            bit_cnt   <= bit_n;
            lat_cnt   <= lat_n;
            shreg     <= shreg_n;
            pend_reg  <= pend_reg_n;
            pend_full <= pend_full_n;
            overrun   <= ovr_n;
            ser_clk   <= ser_clk_n;
            ser_data  <= ser_data_n;
            ser_latch <= ser_latch_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_trx_ctrl_shifter.sv
// tb_trx_ctrl_shifter: scoreboard bench for trx_ctrl_shifter with a
// default-parameter instance (a_*) and a minimum-parameter one (b_*).
module tb_trx_ctrl_shifter;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;

    logic [31:0] a_in = '0;
    logic        a_vld = 1'b0;
    logic        a_clk, a_data, a_latch, a_busy, a_done, a_ovr;

    logic [7:0]  b_in = '0;
    logic        b_vld = 1'b0;
    logic        b_clk, b_data, b_latch, b_busy, b_done, b_ovr;

    int errors = 0;
    int checks = 0;

    logic [31:0] qa[$];
    logic [7:0]  qb[$];

    always #5 ACLK = ~ACLK;

    trx_ctrl_shifter #(
        .DATA_WIDTH(32), .CLK_DIV(4), .LATCH_CYCLES(2)
    ) dut_a (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .in_data(a_in), .in_valid(a_vld),
        .ser_clk(a_clk), .ser_data(a_data), .ser_latch(a_latch),
        .busy(a_busy), .done(a_done), .overrun(a_ovr)
    );

    trx_ctrl_shifter #(
        .DATA_WIDTH(8), .CLK_DIV(1), .LATCH_CYCLES(1)
    ) dut_b (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .in_data(b_in), .in_valid(b_vld),
        .ser_clk(b_clk), .ser_data(b_data), .ser_latch(b_latch),
        .busy(b_busy), .done(b_done), .overrun(b_ovr)
    );

    task automatic chk(input string n, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int          anb = 0, alc = 0;
    logic        apc = 0, apd = 0, apl = 0;
    logic [31:0] aw = '0;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            anb = 0; alc = 0; apc = 0; apd = 0; apl = 0;
        end else begin
            if (a_clk) chk("a_data_stable", 64'(a_data), 64'(apd));
            if (a_clk && !apc) begin
                aw = {aw[30:0], a_data};
                anb++;
            end
            if (a_latch && !apl) begin
                chk("a_bit_count", 64'(anb), 64'd32);
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_frame: got %0h expected none", aw);
                end else begin
                    chk("a_frame", 64'(aw), 64'(qa.pop_front()));
                end
                anb = 0;
                alc = 1;
            end else if (a_latch) begin
                alc++;
            end
            if (!a_latch && apl) chk("a_latch_len", 64'(alc), 64'd2);
            apc = a_clk; apd = a_data; apl = a_latch;
        end
    end

    int          bnb = 0, blc = 0;
    logic        bpc = 0, bpd = 0, bpl = 0;
    logic [7:0]  bw = '0;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            bnb = 0; blc = 0; bpc = 0; bpd = 0; bpl = 0;
        end else begin
            if (b_clk) chk("b_data_stable", 64'(b_data), 64'(bpd));
            if (b_clk && !bpc) begin
                bw = {bw[6:0], b_data};
                bnb++;
            end
            if (b_latch && !bpl) begin
                chk("b_bit_count", 64'(bnb), 64'd8);
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_frame: got %0h expected none", bw);
                end else begin
                    chk("b_frame", 64'(bw), 64'(qb.pop_front()));
                end
                bnb = 0;
                blc = 1;
            end else if (b_latch) begin
                blc++;
            end
            if (!b_latch && bpl) chk("b_latch_len", 64'(blc), 64'd1);
            bpc = b_clk; bpd = b_data; bpl = b_latch;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the following negedge.
    task automatic send_a(input logic [31:0] w, input bit exp,
                          output time t);
        a_in = w; a_vld = 1'b1;
        if (exp) qa.push_back(w);
        @(posedge ACLK);
        t = $time;
        @(negedge ACLK);
        a_vld = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] w, output time t);
        b_in = w; b_vld = 1'b1;
        qb.push_back(w);
        @(posedge ACLK);
        t = $time;
        @(negedge ACLK);
        b_vld = 1'b0;
    endtask

    // Edge time at which the watched output was first seen high.
    task automatic wait_hi(input string n, input bit sel_b,
                           input bit sel_clk, output time te);
        bit hit = 0;
        te = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge ACLK);
            if (sel_b) hit = sel_clk ? b_clk : b_done;
            else       hit = sel_clk ? a_clk : a_done;
        end
        if (hit) te = $time - 5;
        else chk({n, "_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic int cyc(input time a, input time b);
        return int'((b - a) / 10);
    endfunction

    // ---------------- directed sequence ----------------
    time t0, t1, td, td2, tr;

    initial begin
        repeat (3) @(negedge ACLK);
        chk("reset_outs_a", 64'({a_clk, a_data, a_latch, a_busy, a_done, a_ovr}), 64'd0);
        chk("reset_outs_b", 64'({b_clk, b_data, b_latch, b_busy, b_done, b_ovr}), 64'd0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // single frame
        send_a(32'hA5C3_0F81, 1, t0);
        chk("single_busy", 64'(a_busy), 64'd1);
        wait_hi("single_rise", 0, 1, tr);
        chk("single_first_rise", 64'(cyc(t0, tr)), 64'd5);
        wait_hi("single_done", 0, 0, td);
        chk("single_done_lat", 64'(cyc(t0, td)), 64'd259);
        @(negedge ACLK);
        chk("single_done_pulse", 64'(a_done), 64'd0);
        chk("single_ovr", 64'(a_ovr), 64'd0);
        @(negedge ACLK);
        chk("single_idle_busy", 64'(a_busy), 64'd0);

        // back-to-back
        send_a(32'h0000_0001, 1, t0);
        repeat (20) @(negedge ACLK);
        send_a(32'h8000_0000, 1, t1);
        wait_hi("b2b_done1", 0, 0, td);
        chk("b2b_done1_lat", 64'(cyc(t0, td)), 64'd259);
        @(negedge ACLK);
        chk("b2b_busy_gap", 64'(a_busy), 64'd1);
        wait_hi("b2b_done2", 0, 0, td2);
        chk("b2b_gap", 64'(cyc(td, td2)), 64'd260);
        chk("b2b_ovr", 64'(a_ovr), 64'd0);
        repeat (2) @(negedge ACLK);

        // coincident write on the consume edge
        send_a(32'h4444_4444, 1, t0);
        send_a(32'h3333_3333, 1, t1);
        chk("coinc_sep", 64'(cyc(t0, t1)), 64'd1);
        wait_hi("coinc_done1", 0, 0, td);
        chk("coinc_done1_lat", 64'(cyc(t0, td)), 64'd259);
        wait_hi("coinc_done2", 0, 0, td2);
        chk("coinc_gap", 64'(cyc(td, td2)), 64'd260);
        chk("coinc_ovr", 64'(a_ovr), 64'd0);
        repeat (2) @(negedge ACLK);

        // overrun
        send_a(32'h5555_5555, 1, t0);
        repeat (30) @(negedge ACLK);
        send_a(32'h1111_1111, 0, t1);
        chk("ovr_before", 64'(a_ovr), 64'd0);
        repeat (5) @(negedge ACLK);
        send_a(32'h2222_2222, 1, t1);
        chk("ovr_set", 64'(a_ovr), 64'd1);
        wait_hi("ovr_done1", 0, 0, td);
        wait_hi("ovr_done2", 0, 0, td);
        repeat (2) @(negedge ACLK);
        send_a(32'h0F0F_0F0F, 1, t0);
        wait_hi("ovr_done3", 0, 0, td);
        chk("ovr_sticky", 64'(a_ovr), 64'd1);
        repeat (2) @(negedge ACLK);

        // reset mid-frame with a word pending
        send_a(32'hFFFF_FFFF, 0, t0);
        for (int i = 0; i < 2000 && anb < 10; i++) @(negedge ACLK);
        chk("rst_bits_seen", 64'(anb), 64'd10);
        send_a(32'h1234_5678, 0, t1);
        #2 ARESETN = 1'b0;
        #1;
        chk("rst_outs_a", 64'({a_clk, a_data, a_latch, a_busy, a_done, a_ovr}), 64'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (300) @(negedge ACLK);
        chk("rst_after_busy", 64'(a_busy), 64'd0);
        chk("rst_after_bits", 64'(anb), 64'd0);
        chk("rst_after_ovr", 64'(a_ovr), 64'd0);
        chk("a_queue_empty", 64'(qa.size()), 64'd0);

        // minimum parameters
        send_b(8'h5A, t0);
        wait_hi("min_rise", 1, 1, tr);
        chk("min_first_rise", 64'(cyc(t0, tr)), 64'd2);
        wait_hi("min_done", 1, 0, td);
        chk("min_done_lat", 64'(cyc(t0, td)), 64'd18);
        chk("min_ovr", 64'(b_ovr), 64'd0);
        repeat (3) @(negedge ACLK);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
